// File: rtl/wish_unpack_core.sv
// wish_unpack_core: unpacks one NUM_PACK*DATA_WIDTH word into NUM_PACK DATA_WIDTH beats
//   clk_i, rst_i (sync, active-low)
//   s_stb_i/s_cyc_i/s_dat_i/s_tgc_i in, s_ack_o/s_stall_o out : wide source port
//   d_stb_o/d_cyc_o/d_dat_o/d_tgc_o out, d_ack_i in           : narrow sink port
module wish_unpack_core #(
   parameter int DATA_WIDTH    = 8,
   parameter int NUM_PACK      = 4,
   parameter int TGC_WIDTH     = 2,
   parameter int LITTLE_ENDIAN = 1
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           s_stb_i,
   input  logic                           s_cyc_i,
   output logic                           s_ack_o,
   output logic                           s_stall_o,
   input  logic [DATA_WIDTH*NUM_PACK-1:0] s_dat_i,
   input  logic [TGC_WIDTH-1:0]           s_tgc_i,
   output logic                           d_stb_o,
   output logic                           d_cyc_o,
   input  logic                           d_ack_i,
   output logic [DATA_WIDTH-1:0]          d_dat_o,
   output logic [TGC_WIDTH-1:0]           d_tgc_o
);
   localparam int IW = $clog2(NUM_PACK);
   logic                           valid;
   logic [IW-1:0]                  idx;
   logic [DATA_WIDTH*NUM_PACK-1:0] word;
   logic [TGC_WIDTH-1:0]           tag;
   logic [DATA_WIDTH-1:0]          dat;
   logic                           take, last;
   function automatic logic [DATA_WIDTH-1:0] beat(input logic [DATA_WIDTH*NUM_PACK-1:0] w, input int i);
      return (LITTLE_ENDIAN != 0) ? w[i*DATA_WIDTH +: DATA_WIDTH] : w[(NUM_PACK-1-i)*DATA_WIDTH +: DATA_WIDTH];
   endfunction
   always_comb begin
      take      = valid & d_ack_i;
      last      = take & (idx == IW'(NUM_PACK-1));
      s_stall_o = !rst_i | (valid & !last);
      s_ack_o   = s_stb_i & s_cyc_i & !s_stall_o & rst_i;
      d_stb_o   = valid;
      d_cyc_o   = valid;
      d_dat_o   = dat;
      d_tgc_o   = tag;
   end
   // The beat is registered so d_dat_o has no path from d_ack_i and keeps the
   // last beat visible while the buffer is empty.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         valid <= 1'b0;
         idx   <= '0;
         word  <= '0;
         tag   <= '0;
         dat   <= '0;
      end else if (s_ack_o) begin
         valid <= 1'b1;
         idx   <= '0;
         word  <= s_dat_i;
         tag   <= s_tgc_i;
         dat   <= beat(s_dat_i, 0);
      end else if (last) begin
         valid <= 1'b0;
         idx   <= '0;
      end else if (take) begin
         idx   <= idx + IW'(1);
         dat   <= beat(word, int'(idx) + 1);
      end
   end
endmodule

// File: tb/tb_wish_unpack_core.sv
// tb_wish_unpack_core: self-checking bench for both beat orders of wish_unpack_core
module tb_wish_unpack_core;
   logic clk = 0, rst_i = 0, s_stb = 0, s_cyc = 0, d_ack = 0;
   logic [31:0] s_dat = '0;
   logic [1:0] s_tgc = '0;
   logic s_ack, s_stall, d_stb, d_cyc, b_s_ack, b_s_stall, b_d_stb, b_d_cyc;
   logic [7:0] d_dat, b_d_dat;
   logic [1:0] d_tgc, b_d_tgc;
   int errs = 0, checks = 0;
   typedef struct {logic [7:0] le; logic [7:0] be; logic [1:0] tg;} ent_t;
   ent_t q[$];
   always #5 clk = ~clk;
   wish_unpack_core #(.DATA_WIDTH(8), .NUM_PACK(4), .TGC_WIDTH(2), .LITTLE_ENDIAN(1)) dut (
      .clk_i(clk), .rst_i(rst_i), .s_stb_i(s_stb), .s_cyc_i(s_cyc), .s_ack_o(s_ack), .s_stall_o(s_stall),
      .s_dat_i(s_dat), .s_tgc_i(s_tgc), .d_stb_o(d_stb), .d_cyc_o(d_cyc), .d_ack_i(d_ack), .d_dat_o(d_dat), .d_tgc_o(d_tgc));
   wish_unpack_core #(.DATA_WIDTH(8), .NUM_PACK(4), .TGC_WIDTH(2), .LITTLE_ENDIAN(0)) dut_be (
      .clk_i(clk), .rst_i(rst_i), .s_stb_i(s_stb), .s_cyc_i(s_cyc), .s_ack_o(b_s_ack), .s_stall_o(b_s_stall),
      .s_dat_i(s_dat), .s_tgc_i(s_tgc), .d_stb_o(b_d_stb), .d_cyc_o(b_d_cyc), .d_ack_i(d_ack), .d_dat_o(b_d_dat), .d_tgc_o(b_d_tgc));
   function automatic logic [7:0] byte_of(input logic [31:0] w, input int n);
      return 8'(w >> (8 * n));
   endfunction
   task automatic test_reset();
      rst_i = 0; s_stb = 1; s_cyc = 1; d_ack = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         checks++; if (s_ack !== 1'b0) begin errs++; $display("FAIL reset_ack got=%b exp=0", s_ack); end
         checks++; if (s_stall !== 1'b1) begin errs++; $display("FAIL reset_stall got=%b exp=1", s_stall); end
         checks++; if (d_stb !== 1'b0 || d_cyc !== 1'b0) begin errs++; $display("FAIL reset_stb_cyc got=%b%b exp=00", d_stb, d_cyc); end
         checks++; if (d_dat !== 8'h00 || d_tgc !== 2'b00) begin errs++; $display("FAIL reset_dat_tgc got=%h/%b exp=00/00", d_dat, d_tgc); end
      end
      @(negedge clk); rst_i = 1; #1;
      checks++; if (s_ack !== 1'b1) begin errs++; $display("FAIL release_ack got=%b exp=1", s_ack); end
      s_stb = 0;
   endtask
   task automatic test_little_endian();
      logic [7:0] exp [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      @(negedge clk); s_stb = 1; s_cyc = 1; s_dat = 32'hDDCCBBAA; s_tgc = 2'b10; d_ack = 1; #1;
      checks++; if (s_ack !== 1'b1) begin errs++; $display("FAIL le_accept got=%b exp=1", s_ack); end
      for (int j = 0; j < 4; j++) begin
         @(negedge clk); s_stb = 0; #1;
         checks++; if (d_stb !== 1'b1 || d_cyc !== 1'b1) begin errs++; $display("FAIL le_stb beat=%0d got=%b%b exp=11", j, d_stb, d_cyc); end
         checks++; if (d_dat !== exp[j]) begin errs++; $display("FAIL le_dat beat=%0d got=%h exp=%h", j, d_dat, exp[j]); end
         checks++; if (d_tgc !== 2'b10) begin errs++; $display("FAIL le_tgc beat=%0d got=%b exp=10", j, d_tgc); end
      end
      @(negedge clk); #1;
      checks++; if (d_stb !== 1'b0) begin errs++; $display("FAIL le_drop got=%b exp=0", d_stb); end
      checks++; if (d_dat !== 8'hDD) begin errs++; $display("FAIL le_hold got=%h exp=dd", d_dat); end
   endtask
   task automatic test_big_endian();
      logic [7:0] exp [4] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
      @(negedge clk); s_stb = 1; s_cyc = 1; s_dat = 32'hDDCCBBAA; s_tgc = 2'b01; d_ack = 1; #1;
      checks++; if (b_s_ack !== 1'b1) begin errs++; $display("FAIL be_accept got=%b exp=1", b_s_ack); end
      for (int j = 0; j < 4; j++) begin
         @(negedge clk); s_stb = 0; #1;
         checks++; if (b_d_stb !== 1'b1 || b_d_dat !== exp[j]) begin errs++; $display("FAIL be_dat beat=%0d got=%b/%h exp=1/%h", j, b_d_stb, b_d_dat, exp[j]); end
         checks++; if (b_d_tgc !== 2'b01) begin errs++; $display("FAIL be_tgc beat=%0d got=%b exp=01", j, b_d_tgc); end
      end
      @(negedge clk); #1;
      checks++; if (b_d_stb !== 1'b0 || b_d_dat !== 8'hAA) begin errs++; $display("FAIL be_drop got=%b/%h exp=0/aa", b_d_stb, b_d_dat); end
   endtask
   task automatic test_backpressure();
      logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      int b = 0, c = 0;
      @(negedge clk); s_stb = 1; s_cyc = 1; s_dat = 32'h44332211; s_tgc = 2'b11; d_ack = 0; #1;
      checks++; if (s_ack !== 1'b1) begin errs++; $display("FAIL bp_accept got=%b exp=1", s_ack); end
      while (b < 4 && c < 20) begin
         @(negedge clk); s_stb = 0; d_ack = (c % 3 == 0); #1;
         checks++; if (d_stb !== 1'b1 || d_dat !== exp[b]) begin errs++; $display("FAIL bp_dat cyc=%0d got=%b/%h exp=1/%h", c, d_stb, d_dat, exp[b]); end
         checks++; if (s_stall !== !(b == 3 && d_ack)) begin errs++; $display("FAIL bp_stall cyc=%0d got=%b exp=%b", c, s_stall, !(b == 3 && d_ack)); end
         if (d_ack) b++;
         c++;
      end
      checks++; if (b != 4) begin errs++; $display("FAIL bp_timeout got=%0d beats exp=4", b); end
      @(negedge clk); d_ack = 0; #1;
      checks++; if (d_stb !== 1'b0 || d_dat !== 8'h44) begin errs++; $display("FAIL bp_drop got=%b/%h exp=0/44", d_stb, d_dat); end
   endtask
   task automatic test_back_to_back();
      @(negedge clk); s_stb = 1; s_cyc = 1; s_dat = 32'h04030201; s_tgc = 2'b00; d_ack = 1; #1;
      checks++; if (s_ack !== 1'b1) begin errs++; $display("FAIL b2b_accept got=%b exp=1", s_ack); end
      for (int k = 0; k < 8; k++) begin
         @(negedge clk); s_dat = 32'h08070605; if (k == 4) s_stb = 0; #1;
         checks++; if (d_stb !== 1'b1 || d_dat !== 8'(k + 1)) begin errs++; $display("FAIL b2b_dat beat=%0d got=%b/%h exp=1/%h", k, d_stb, d_dat, 8'(k + 1)); end
         checks++; if (s_ack !== (k == 3)) begin errs++; $display("FAIL b2b_ack beat=%0d got=%b exp=%b", k, s_ack, k == 3); end
      end
      @(negedge clk); #1;
      checks++; if (d_stb !== 1'b0) begin errs++; $display("FAIL b2b_drop got=%b exp=0", d_stb); end
   endtask
   task automatic test_reset_mid_word();
      @(negedge clk); s_stb = 1; s_cyc = 1; s_dat = 32'hDDCCBBAA; s_tgc = 2'b10; d_ack = 1; #1;
      checks++; if (s_ack !== 1'b1) begin errs++; $display("FAIL mid_accept got=%b exp=1", s_ack); end
      @(negedge clk); s_stb = 0; #1;
      checks++; if (d_dat !== 8'hAA) begin errs++; $display("FAIL mid_aa got=%h exp=aa", d_dat); end
      @(negedge clk); #1;
      checks++; if (d_dat !== 8'hBB) begin errs++; $display("FAIL mid_bb got=%h exp=bb", d_dat); end
      @(negedge clk); rst_i = 0; s_stb = 1; #1;
      checks++; if (s_ack !== 1'b0 || s_stall !== 1'b1) begin errs++; $display("FAIL mid_rst_comb got=%b%b exp=01", s_ack, s_stall); end
      @(negedge clk); s_stb = 0; #1;
      checks++; if (d_stb !== 1'b0 || d_dat !== 8'h00 || d_tgc !== 2'b00) begin errs++; $display("FAIL mid_rst_out got=%b/%h/%b exp=0/00/00", d_stb, d_dat, d_tgc); end
      @(negedge clk); rst_i = 1; s_stb = 1; s_dat = 32'h87654321; s_tgc = 2'b01; #1;
      checks++; if (s_ack !== 1'b1) begin errs++; $display("FAIL mid_reaccept got=%b exp=1", s_ack); end
      @(negedge clk); s_stb = 0; #1;
      checks++; if (d_stb !== 1'b1 || d_dat !== 8'h21) begin errs++; $display("FAIL mid_first got=%b/%h exp=1/21", d_stb, d_dat); end
      for (int j = 0; j < 4; j++) @(negedge clk);
   endtask
   task automatic test_random();
      logic [7:0] hl = 0, hb = 0, el, eb;
      logic [1:0] ht = 0, et;
      logic es, est, ea;
      q.delete();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         rst_i = (i == 0) ? 1'b0 : ($urandom_range(39) != 0);
         s_stb = 1'($urandom_range(1)); s_cyc = ($urandom_range(3) != 0); d_ack = 1'($urandom_range(1));
         s_dat = $urandom; s_tgc = 2'($urandom_range(3));
         #1;
         es  = q.size() != 0;
         est = !rst_i || (es && !(q.size() == 1 && d_ack));
         ea  = s_stb && s_cyc && !est && rst_i;
         el  = es ? q[0].le : hl;
         eb  = es ? q[0].be : hb;
         et  = es ? q[0].tg : ht;
         if (i > 0) begin
            checks++; if (s_ack !== ea || b_s_ack !== ea) begin errs++; $display("FAIL rnd_ack i=%0d got=%b/%b exp=%b", i, s_ack, b_s_ack, ea); end
            checks++; if (s_stall !== est) begin errs++; $display("FAIL rnd_stall i=%0d got=%b exp=%b", i, s_stall, est); end
            checks++; if (d_stb !== es || d_cyc !== es) begin errs++; $display("FAIL rnd_stb i=%0d got=%b%b exp=%b", i, d_stb, d_cyc, es); end
            checks++; if (d_dat !== el) begin errs++; $display("FAIL rnd_le_dat i=%0d got=%h exp=%h", i, d_dat, el); end
            checks++; if (b_d_dat !== eb) begin errs++; $display("FAIL rnd_be_dat i=%0d got=%h exp=%h", i, b_d_dat, eb); end
            checks++; if (d_tgc !== et || b_d_tgc !== et) begin errs++; $display("FAIL rnd_tgc i=%0d got=%b/%b exp=%b", i, d_tgc, b_d_tgc, et); end
         end
         @(posedge clk);
         if (!rst_i) begin
            q.delete(); hl = 0; hb = 0; ht = 0;
         end else begin
            if (es) begin hl = q[0].le; hb = q[0].be; ht = q[0].tg; end
            if (es && d_ack) void'(q.pop_front());
            if (ea) for (int n = 0; n < 4; n++) q.push_back('{le: byte_of(s_dat, n), be: byte_of(s_dat, 3 - n), tg: s_tgc});
         end
      end
   endtask
   initial begin
      test_reset();
      test_little_endian();
      test_big_endian();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_word();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/wish_unpack_core.md
Name: wish_unpack_core

Overview:
- Wishbone-style width down-converter. Accepts one wide word of NUM_PACK*DATA_WIDTH bits on a slave (s_) port and emits it as NUM_PACK consecutive DATA_WIDTH-bit beats on a master (d_) port.
- Sits between a wide producer and a narrow consumer.
- Single-entry buffer with a beat index. Back-to-back wide words stream with no bubble.

Parameters:
- DATA_WIDTH, 8: width of one output beat.
- NUM_PACK, 4: beats per input word; must be >= 2.
- TGC_WIDTH, 2: width of the cycle tag carried with each word.
- LITTLE_ENDIAN, 1: 1 = beat 0 is the least-significant slice; 0 = beat 0 is the most-significant slice.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous reset, active-low (0 = reset).
- s_stb_i  in  1  source strobe.
- s_cyc_i  in  1  source cycle valid.
- s_ack_o  out  1  source word accepted this cycle.
- s_stall_o  out  1  buffer cannot accept a word this cycle.
- s_dat_i  in  DATA_WIDTH*NUM_PACK  wide input word.
- s_tgc_i  in  TGC_WIDTH  tag for the input word.
- d_stb_o  out  1  output beat valid.
- d_cyc_o  out  1  output cycle active.
- d_ack_i  in  1  sink consumed the current beat.
- d_dat_o  out  DATA_WIDTH  current beat.
- d_tgc_o  out  TGC_WIDTH  tag of the word being unpacked.

Behaviour:
- State:
  - valid flag;
  - index register, $clog2(NUM_PACK) bits, range 0..NUM_PACK-1;
  - word register;
  - tag register.
- Reset (rst_i==0 at a clock edge): valid=0, index=0, word=0, tag=0.
  - While rst_i==0: s_ack_o=0 and s_stall_o=1, both forced combinationally.
  - d_stb_o=0, d_cyc_o=0, d_dat_o=0, d_tgc_o=0 from the cycle after the reset edge.
- Definitions:
  - take = d_stb_o & d_ack_i.
  - last = take & (index==NUM_PACK-1).
- s_stall_o = valid & !last.
  - This is combinational.
  - The buffer accepts a new word in the same cycle its final beat is consumed.
- s_ack_o = s_stb_i & s_cyc_i & !s_stall_o & rst_i.
  - This is combinational, the same cycle as the request.
  - An accept happens exactly when s_ack_o=1.
- On accept: word<=s_dat_i, tag<=s_tgc_i, index<=0, valid<=1.
- On take without accept:
  - If not last: index<=index+1.
  - If last: valid<=0, index<=0.
- If take and accept coincide (last beat plus new word): the accept wins and the new word loads. Zero-bubble streaming.
- d_stb_o = valid and d_cyc_o = valid, both registered-state driven.
  - They stay high, with d_dat_o stable, until d_ack_i.
  - d_ack_i while d_stb_o==0 is ignored.
- Beat selection:
  - LITTLE_ENDIAN=1: d_dat_o = word[index*DATA_WIDTH +: DATA_WIDTH].
  - LITTLE_ENDIAN=0: d_dat_o = word[(NUM_PACK-1-index)*DATA_WIDTH +: DATA_WIDTH].
- d_tgc_o = tag and is presented unchanged on every beat of the word.
- When valid==0, d_dat_o and d_tgc_o hold their last values. After reset they are 0.
- Deasserting s_cyc_i does not abort a buffered word; all NUM_PACK beats are still delivered.
- Latency:
  - The first beat is visible one cycle after accept.
  - Full throughput is one beat per cycle when d_ack_i is held high.
  - The source sees one accept every NUM_PACK cycles.
- Reset mid-word discards the remaining beats. There is no partial output after reset.
- No combinational path from d_ack_i to d_dat_o. The paths d_ack_i -> s_stall_o and d_ack_i -> s_ack_o are permitted.

Test Plan:
1. Reset, default parameters: hold rst_i=0 for 2 cycles with s_stb_i=s_cyc_i=1 -> s_ack_o=0, d_stb_o=0, d_cyc_o=0. Release -> s_ack_o=1 in the same cycle, since the buffer is empty.
2. Little-endian unpack:
   - Stimulus: send 0xDDCCBBAA with tgc=2'b10, d_ack_i held 1.
   - Response: d_dat_o = AA, BB, CC, DD on 4 consecutive cycles, d_tgc_o=2'b10 on each beat, d_stb_o drops after DD.
3. Big-endian, LITTLE_ENDIAN=0: send 0xDDCCBBAA -> beats DD, CC, BB, AA.
4. Sink backpressure: d_ack_i toggles 1,0,0,1,... -> d_dat_o holds each beat while d_ack_i=0, no beat skipped or duplicated, s_stall_o=1 until the last beat is acked.
5. Streaming:
   - Stimulus: words 0x04030201 and 0x08070605 offered back to back, d_ack_i=1.
   - Response: 8 contiguous beats 01..08. The second s_ack_o coincides with the ack of beat 04, with no idle cycle.
6. Reset mid-word: assert rst_i=0 after beat BB -> next cycle d_stb_o=0. After release, the next accepted word starts at beat 0.
